regfile_nport: RTL and testbench

//  Parametrised integer register file for the RV32 core: N asynchronous read ports, one synchronous write port.
//  x0 hardwired to zero. After reset, a sequencer clears every register, one per cycle, before the file accepts writes.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_rd_port.sv | 34 +++
 rtl/regfile_nport.sv | 102 ++++++++++
 tb/tb_regfile_nport.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the RV32 integer register file.
package regfile_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_t;

    function automatic int rf_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One asynchronous read port: array mux with x0 and clear-sequence zero gating.
// Same-cycle forwarding of the write port is compiled in with REGFILE_BYPASS_EN.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = 32,
    parameter int AW   = rf_aw(NREG)
) (
    input  logic [NREG*XLEN-1:0] regs_flat,
    input  logic [AW-1:0]        addr,
    input  logic                 init_busy,
`ifdef REGFILE_BYPASS_EN
    input  logic                 fwd_en,
    input  logic [AW-1:0]        wa,
    input  logic [XLEN-1:0]      wd,
`endif
    output logic [XLEN-1:0]      data
);

    always_comb begin
        data = '0;
        if (!init_busy && addr != '0) begin
            data = regs_flat[addr*XLEN +: XLEN];
`ifdef REGFILE_BYPASS_EN
            // fwd_en already excludes x0 writes and the clear sequence
            if (fwd_en && wa == addr) begin
                data = wd;
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_nport.sv
// N-read / 1-write integer register file with a post-reset clear sequencer.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_nport
    import regfile_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    localparam int AW   = rf_aw(NREG)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NRD*AW-1:0]   RD_ADDR,
    output logic [NRD*XLEN-1:0] RD_DATA,
    input  logic                WE,
    input  logic [AW-1:0]       WA,
    input  logic [XLEN-1:0]     WD,
    output logic                INIT_BUSY,
    output logic                WR_DROP
);

    rf_state_t             state;
    rf_state_t             state_nxt;
    logic [AW-1:0]         cnt;
    logic [AW-1:0]         cnt_nxt;
    logic                  wr_drop_q;
    logic                  wr_req;
    logic [XLEN-1:0]       mem [NREG];
    logic [NREG*XLEN-1:0]  regs_flat;

    assign wr_req    = WE && (WA != '0);
    assign INIT_BUSY = (state == RF_INIT);
    assign WR_DROP   = wr_drop_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RF_INIT;
            cnt       <= AW'(1);
            wr_drop_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            wr_drop_q <= (state == RF_INIT) && wr_req;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RF_INIT: begin
                cnt_nxt = cnt + AW'(1);
                if (cnt == AW'(NREG - 1)) begin
                    state_nxt = RF_RUN;
                end
            end
            RF_RUN: begin
                state_nxt = RF_RUN;
            end
            default: begin
                state_nxt = RF_INIT;
            end
        endcase
    end

    // Storage has no reset; the clear sequence zeroes it one entry per edge.
    always_ff @(posedge CLK) begin
        if (state == RF_INIT) begin
            mem[cnt] <= '0;
        end else if (wr_req) begin
            mem[WA] <= WD;
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_flat
        assign regs_flat[r*XLEN +: XLEN] = mem[r];
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_en;
    assign fwd_en = (state == RF_RUN) && wr_req;
`endif

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rd_port #(
            .XLEN (XLEN),
            .NREG (NREG),
            .AW   (AW)
        ) u_rd_port (
            .regs_flat (regs_flat),
            .addr      (RD_ADDR[k*AW +: AW]),
            .init_busy (INIT_BUSY),
`ifdef REGFILE_BYPASS_EN
            .fwd_en    (fwd_en),
            .wa        (WA),
            .wd        (WD),
`endif
            .data      (RD_DATA[k*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_nport.sv
// Directed testbench for regfile_nport (XLEN=32, NREG=32, NRD=2).
module tb_regfile_nport;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                CLK;
    logic                RST;
    logic [NRD*AW-1:0]   RD_ADDR;
    logic [NRD*XLEN-1:0] RD_DATA;
    logic                WE;
    logic [AW-1:0]       WA;
    logic [XLEN-1:0]     WD;
    logic                INIT_BUSY;
    logic                WR_DROP;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            we;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic [XLEN-1:0] exp0;
        logic [XLEN-1:0] exp1;
        logic            exp_drop;
    } vec_t;

    vec_t vecs[10];

    regfile_nport #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RD_ADDR   (RD_ADDR),
        .RD_DATA   (RD_DATA),
        .WE        (WE),
        .WA        (WA),
        .WD        (WD),
        .INIT_BUSY (INIT_BUSY),
        .WR_DROP   (WR_DROP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                                 input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        WE      = we;
        WA      = wa;
        WD      = wd;
        RD_ADDR = {ra1, ra0};
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance until the clear sequence finishes, bounded so a stuck FSM cannot hang the run.
    task automatic waitInit(inout int edges);
        while (INIT_BUSY && edges < 100) begin
            tick();
            edges++;
        end
    endtask

    initial begin
        int edges;
        logic [XLEN-1:0] exp_same;

        // R: we, wa, wd, ra0, ra1, exp0, exp1, exp_drop
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[2] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
        vecs[4] = '{1'b1, 5'd31, 32'h80000001, 5'd5,  5'd30, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[5] = '{1'b1, 5'd30, 32'hFFFFFFFF, 5'd31, 5'd5,  32'h80000001, 32'hDEADBEEF, 1'b0};
        vecs[6] = '{1'b1, 5'd7,  32'h00000011, 5'd30, 5'd31, 32'hFFFFFFFF, 32'h80000001, 1'b0};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd1,  32'h00000011, 32'h0,        1'b0};
        vecs[8] = '{1'b1, 5'd5,  32'h0,        5'd7,  5'd30, 32'h00000011, 32'hFFFFFFFF, 1'b0};
        vecs[9] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'h0,        32'h00000011, 1'b0};

        RST = 1'b1;
        applyStimulus(1'b0, '0, '0, 5'd1, 5'd2);
        repeat (2) tick();
        checkOutput("reset_busy", 32'(INIT_BUSY), 32'd1);
        checkOutput("reset_drop", 32'(WR_DROP), 32'd0);
        checkOutput("reset_rd0", RD_DATA[31:0], 32'h0);

        // Release reset with a write request pending during the clear sequence
        RST = 1'b0;
        applyStimulus(1'b1, 5'd3, 32'h000000FF, 5'd3, 5'd3);
        edges = 0;
        tick();
        edges++;
        checkOutput("init_drop_pulse", 32'(WR_DROP), 32'd1);
        checkOutput("init_busy_edge1", 32'(INIT_BUSY), 32'd1);
        checkOutput("init_rd_zero", RD_DATA[31:0], 32'h0);
        applyStimulus(1'b0, '0, '0, 5'd3, 5'd3);
        tick();
        edges++;
        checkOutput("init_drop_clear", 32'(WR_DROP), 32'd0);
        waitInit(edges);
        checkOutput("init_edge_count", 32'(edges), 32'd31);
        checkOutput("run_busy", 32'(INIT_BUSY), 32'd0);

        for (int a = 0; a < NREG; a++) begin
            applyStimulus(1'b0, '0, '0, AW'(a), AW'(NREG - 1 - a));
            checkOutput($sformatf("clear_p0_r%0d", a), RD_DATA[31:0], 32'h0);
            checkOutput($sformatf("clear_p1_r%0d", NREG - 1 - a), RD_DATA[63:32], 32'h0);
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1);
            checkOutput($sformatf("vec%0d_p0", i), RD_DATA[31:0], vecs[i].exp0);
            checkOutput($sformatf("vec%0d_p1", i), RD_DATA[63:32], vecs[i].exp1);
            checkOutput($sformatf("vec%0d_drop", i), 32'(WR_DROP), 32'(vecs[i].exp_drop));
            tick();
        end

        // Same-cycle read and write of reg7 (holds 0x11)
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hA5A5A5A5;
`else
        exp_same = 32'h00000011;
`endif
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
        checkOutput("same_cycle_p0", RD_DATA[31:0], exp_same);
        checkOutput("same_cycle_p1", RD_DATA[63:32], exp_same);
        tick();
        applyStimulus(1'b0, '0, '0, 5'd7, 5'd0);
        checkOutput("after_edge_p0", RD_DATA[31:0], 32'hA5A5A5A5);
        checkOutput("after_edge_x0", RD_DATA[63:32], 32'h0);

        // Reset in the middle of RUN with reg9 populated
        applyStimulus(1'b1, 5'd9, 32'h00000099, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd4, 32'h00000044, 5'd9, 5'd9);
        checkOutput("reg9_written", RD_DATA[31:0], 32'h00000099);
        RST = 1'b1;
        #1;
        checkOutput("midrun_busy", 32'(INIT_BUSY), 32'd1);
        checkOutput("midrun_rd_zero", RD_DATA[63:32], 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("rst_hold_drop%0d", c), 32'(WR_DROP), 32'd0);
        end
        applyStimulus(1'b0, '0, '0, 5'd9, 5'd4);
        RST = 1'b0;
        edges = 0;
        waitInit(edges);
        checkOutput("reinit_edge_count", 32'(edges), 32'd31);
        checkOutput("reinit_reg9", RD_DATA[31:0], 32'h0);
        checkOutput("reinit_reg4", RD_DATA[63:32], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
